// File: rtl/fetch_queue_pkg.sv
// Shared widths, queue entry layout and the skip-zero ID successor used by fetch_queue.
package fetch_queue_pkg;

  localparam int INST_WIDTH           = 32;
  localparam int ADDR_WIDTH           = 32;
  localparam int INSTRUCTION_ID_WIDTH = 4;
  localparam int FETCH_QUEUE_DEPTH    = 4;

  typedef struct packed {
    logic [INST_WIDTH-1:0]           inst0;
    logic [INST_WIDTH-1:0]           inst1;
    logic [ADDR_WIDTH-1:0]           pc0;
    logic [INSTRUCTION_ID_WIDTH-1:0] id0;
    logic [INSTRUCTION_ID_WIDTH-1:0] id1;
  } fq_entry_t;

  // ID 0 is reserved for bubbles, so the counter wraps from all-ones to 1.
  function automatic logic [INSTRUCTION_ID_WIDTH-1:0] id_succ(
    input logic [INSTRUCTION_ID_WIDTH-1:0] x
  );
    return (x == '1) ? INSTRUCTION_ID_WIDTH'(1) : x + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_queue_id_gen.sv
// Skip-zero instruction ID counter; advances by one pair of IDs per accepted push.
module id_gen
  import fetch_queue_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            adv,
  output logic [INSTRUCTION_ID_WIDTH-1:0] next_id,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id0,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id1
);

  assign id0 = next_id;
  assign id1 = id_succ(next_id);

  always_ff @(posedge clk) begin
    if (!rst_n)
      next_id <= INSTRUCTION_ID_WIDTH'(1);
    else if (adv)
      next_id <= id_succ(id1);
  end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue fetch queue: circular buffer of instruction pairs with registered issue outputs.
// Optional same-cycle bypass into the output registers when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            stall,
  input  logic                            fetch_vld,
  output logic                            fetch_rdy,
  input  logic [INST_WIDTH-1:0]           fetch_instruction0,
  input  logic [INST_WIDTH-1:0]           fetch_instruction1,
  input  logic [ADDR_WIDTH-1:0]           fetch_pc,
  output logic [INST_WIDTH-1:0]           instruction0_out,
  output logic [INST_WIDTH-1:0]           instruction1_out,
  output logic [ADDR_WIDTH-1:0]           pc0_out,
  output logic [ADDR_WIDTH-1:0]           pc1_out,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id0_out,
  output logic [INSTRUCTION_ID_WIDTH-1:0] id1_out,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t                       mem [DEPTH];
  fq_entry_t                       new_entry;
  fq_entry_t                       out_q;
  logic [ADDR_WIDTH-1:0]           pc1_q;
  logic [PTR_W-1:0]                head;
  logic [PTR_W-1:0]                tail;
  logic [PTR_W:0]                  count;
  logic                            push;
  logic                            pop;
  logic                            bypass;
  logic                            enq;
  logic [INSTRUCTION_ID_WIDTH-1:0] gen_id0;
  logic [INSTRUCTION_ID_WIDTH-1:0] gen_id1;
  logic [INSTRUCTION_ID_WIDTH-1:0] unused_next_id;

  assign fetch_rdy = count < (PTR_W+1)'(DEPTH);
  assign empty     = count == '0;
  assign push      = fetch_vld && fetch_rdy && !flush;
  assign pop       = !stall && !flush && !empty;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push && empty && !stall;
`else
  assign bypass = 1'b0;
`endif

  assign enq = push && !bypass;

  id_gen u_id_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .adv     (push),
    .next_id (unused_next_id),
    .id0     (gen_id0),
    .id1     (gen_id1)
  );

  assign new_entry = '{inst0: fetch_instruction0, inst1: fetch_instruction1,
                       pc0: fetch_pc, id0: gen_id0, id1: gen_id1};

  always_ff @(posedge clk) begin
    if (enq)
      mem[tail] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)
        tail <= tail + 1'b1;
      if (pop)
        head <= head + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Pop and bypass are mutually exclusive: bypass only fires on an empty queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_q <= '0;
      pc1_q <= '0;
    end else if (!stall) begin
      if (pop) begin
        out_q <= mem[head];
        pc1_q <= mem[head].pc0 + 1'b1;
      end else if (bypass) begin
        out_q <= new_entry;
        pc1_q <= fetch_pc + 1'b1;
      end else begin
        out_q <= '0;
        pc1_q <= '0;
      end
    end
  end

  assign instruction0_out = out_q.inst0;
  assign instruction1_out = out_q.inst1;
  assign pc0_out          = out_q.pc0;
  assign pc1_out          = pc1_q;
  assign id0_out          = out_q.id0;
  assign id1_out          = out_q.id1;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH  = FETCH_QUEUE_DEPTH;
  localparam int ID_MAX = (1 << INSTRUCTION_ID_WIDTH) - 1;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYPASS  = 1'b1;
  localparam int EXP_LAT = 1;
`else
  localparam bit BYPASS  = 1'b0;
  localparam int EXP_LAT = 2;
`endif

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            flush = 1'b0;
  logic                            stall = 1'b0;
  logic                            fetch_vld = 1'b0;
  logic                            fetch_rdy;
  logic [INST_WIDTH-1:0]           fetch_instruction0 = '0;
  logic [INST_WIDTH-1:0]           fetch_instruction1 = '0;
  logic [ADDR_WIDTH-1:0]           fetch_pc = '0;
  logic [INST_WIDTH-1:0]           instruction0_out;
  logic [INST_WIDTH-1:0]           instruction1_out;
  logic [ADDR_WIDTH-1:0]           pc0_out;
  logic [ADDR_WIDTH-1:0]           pc1_out;
  logic [INSTRUCTION_ID_WIDTH-1:0] id0_out;
  logic [INSTRUCTION_ID_WIDTH-1:0] id1_out;
  logic                            empty;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  fetch_queue dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .stall              (stall),
    .fetch_vld          (fetch_vld),
    .fetch_rdy          (fetch_rdy),
    .fetch_instruction0 (fetch_instruction0),
    .fetch_instruction1 (fetch_instruction1),
    .fetch_pc           (fetch_pc),
    .instruction0_out   (instruction0_out),
    .instruction1_out   (instruction1_out),
    .pc0_out            (pc0_out),
    .pc1_out            (pc1_out),
    .id0_out            (id0_out),
    .id1_out            (id1_out),
    .empty              (empty)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of pairs plus the presented pair.
  typedef struct {
    logic [INST_WIDTH-1:0] i0;
    logic [INST_WIDTH-1:0] i1;
    logic [ADDR_WIDTH-1:0] pc0;
    logic [ADDR_WIDTH-1:0] pc1;
    int                    id0;
    int                    id1;
  } pair_t;

  pair_t mq[$];
  pair_t mout;
  pair_t np;
  int    mnext;
  bit    acc;

  function automatic int nextId(input int x);
    return (x % ID_MAX) + 1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mout  = '{default: '0};
      mnext = 1;
    end else if (flush) begin
      mq.delete();
      mout = '{default: '0};
    end else begin
      acc = fetch_vld && (mq.size() < DEPTH);
      if (acc) begin
        np.i0  = fetch_instruction0;
        np.i1  = fetch_instruction1;
        np.pc0 = fetch_pc;
        np.pc1 = fetch_pc + 1;
        np.id0 = mnext;
        np.id1 = nextId(mnext);
        mnext  = nextId(np.id1);
      end
      if (!stall) begin
        if (mq.size() > 0) begin
          mout = mq.pop_front();
        end else if (acc && BYPASS) begin
          mout = np;
          acc  = 1'b0;
        end else begin
          mout = '{default: '0};
        end
      end
      if (acc)
        mq.push_back(np);
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_inst0", 64'(instruction0_out), 64'(mout.i0));
      checkOutput("m_inst1", 64'(instruction1_out), 64'(mout.i1));
      checkOutput("m_pc0", 64'(pc0_out), 64'(mout.pc0));
      checkOutput("m_pc1", 64'(pc1_out), 64'(mout.pc1));
      checkOutput("m_id0", 64'(id0_out), 64'(mout.id0));
      checkOutput("m_id1", 64'(id1_out), 64'(mout.id1));
      checkOutput("m_rdy", 64'(fetch_rdy), 64'(mq.size() < DEPTH));
      checkOutput("m_empty", 64'(empty), 64'(mq.size() == 0));
    end
  end

  task automatic applyStimulus(input bit rn, input bit vld, input int i0, input int i1,
                               input int pc, input bit stl, input bit fl);
    rst_n              = rn;
    fetch_vld          = vld;
    fetch_instruction0 = INST_WIDTH'(i0);
    fetch_instruction1 = INST_WIDTH'(i1);
    fetch_pc           = ADDR_WIDTH'(pc);
    stall              = stl;
    flush              = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit stl);
    applyStimulus(1'b1, 1'b0, 0, 0, 0, stl, 1'b0);
  endtask

  // Steps idle cycles until a valid pair is presented; lat counts edges including the push.
  task automatic waitPresent(inout int lat);
    for (int k = 0; k < 4 && id0_out == '0; k++) begin
      idle(1'b0);
      lat++;
    end
    checkOutput("present_timeout", 64'(id0_out != '0), 64'(1));
  endtask

  int lat;

  initial begin
    // Reset and single push
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    checkEn = 1'b1;
    checkOutput("rst_id0", 64'(id0_out), 64'(0));
    checkOutput("rst_rdy", 64'(fetch_rdy), 64'(1));
    checkOutput("rst_empty", 64'(empty), 64'(1));
    applyStimulus(1'b1, 1'b1, 'h11, 'h22, 'h40, 1'b0, 1'b0);
    lat = 1;
    waitPresent(lat);
    checkOutput("t1_latency", 64'(lat), 64'(EXP_LAT));
    checkOutput("t1_inst0", 64'(instruction0_out), 64'h11);
    checkOutput("t1_inst1", 64'(instruction1_out), 64'h22);
    checkOutput("t1_pc0", 64'(pc0_out), 64'h40);
    checkOutput("t1_pc1", 64'(pc1_out), 64'h41);
    checkOutput("t1_id0", 64'(id0_out), 64'd1);
    checkOutput("t1_id1", 64'(id1_out), 64'd2);
    idle(1'b0);
    checkOutput("t1_bubble_id0", 64'(id0_out), 64'd0);
    checkOutput("t1_bubble_inst0", 64'(instruction0_out), 64'd0);

    // Fill to full under stall, then drain with a stall hold in the middle
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b1, 'h100 + k, 'h200 + k, 'h1000 + 2 * k, 1'b1, 1'b0);
      if (k == 3) checkOutput("full_rdy", 64'(fetch_rdy), 64'd0);
    end
    checkOutput("full_rdy_after5", 64'(fetch_rdy), 64'd0);
    checkOutput("full_id0_held", 64'(id0_out), 64'd0);
    idle(1'b0);
    checkOutput("pop1_id0", 64'(id0_out), 64'd1);
    checkOutput("pop1_inst0", 64'(instruction0_out), 64'h100);
    idle(1'b0);
    checkOutput("pop2_id0", 64'(id0_out), 64'd3);
    idle(1'b0);
    checkOutput("pop3_id0", 64'(id0_out), 64'd5);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      checkOutput("stall_id0", 64'(id0_out), 64'd5);
      checkOutput("stall_id1", 64'(id1_out), 64'd6);
      checkOutput("stall_pc0", 64'(pc0_out), 64'h1004);
    end
    idle(1'b0);
    checkOutput("pop4_id0", 64'(id0_out), 64'd7);
    checkOutput("pop4_id1", 64'(id1_out), 64'd8);
    checkOutput("pop4_pc1", 64'(pc1_out), 64'h1007);
    idle(1'b0);
    checkOutput("drain_id0", 64'(id0_out), 64'd0);
    checkOutput("drain_empty", 64'(empty), 64'd1);

    // Flush with three pairs queued; flush-cycle push is dropped
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b1, 'h300 + k, 'h400 + k, 'h2000 + 4 * k, 1'b1, 1'b0);
    checkOutput("preflush_empty", 64'(empty), 64'd0);
    applyStimulus(1'b1, 1'b1, 'hdead, 'hbeef, 'h3000, 1'b0, 1'b1);
    checkOutput("flush_id0", 64'(id0_out), 64'd0);
    checkOutput("flush_inst0", 64'(instruction0_out), 64'd0);
    checkOutput("flush_empty", 64'(empty), 64'd1);
    checkOutput("flush_rdy", 64'(fetch_rdy), 64'd1);

    // IDs continue after the flush (9..14 used) and wrap past 15 skipping 0
    applyStimulus(1'b1, 1'b1, 'h500, 'h501, 'h5000, 1'b0, 1'b0);
    lat = 1;
    waitPresent(lat);
    checkOutput("wrap_a_id0", 64'(id0_out), 64'd15);
    checkOutput("wrap_a_id1", 64'(id1_out), 64'd1);
    checkOutput("wrap_a_inst0", 64'(instruction0_out), 64'h500);
    applyStimulus(1'b1, 1'b1, 'h600, 'h601, 'h6000, 1'b0, 1'b0);
    lat = 1;
    waitPresent(lat);
    checkOutput("wrap_b_id0", 64'(id0_out), 64'd2);
    checkOutput("wrap_b_id1", 64'(id1_out), 64'd3);

    // Reset mid-operation with the queue half full and stall held
    applyStimulus(1'b1, 1'b1, 'h700, 'h701, 'h7000, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 'h710, 'h711, 'h7010, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 'h720, 'h721, 'h7020, 1'b1, 1'b0);
    checkOutput("midrst_id0", 64'(id0_out), 64'd0);
    checkOutput("midrst_pc0", 64'(pc0_out), 64'd0);
    checkOutput("midrst_rdy", 64'(fetch_rdy), 64'd1);
    checkOutput("midrst_empty", 64'(empty), 64'd1);
    applyStimulus(1'b1, 1'b1, 'h800, 'h801, 'h8000, 1'b0, 1'b0);
    lat = 1;
    waitPresent(lat);
    checkOutput("midrst_next_id0", 64'(id0_out), 64'd1);
    checkOutput("midrst_next_id1", 64'(id1_out), 64'd2);
    checkOutput("midrst_inst1", 64'(instruction1_out), 64'h801);

    // Back-to-back pushes for throughput
    for (int k = 0; k < 6; k++)
      applyStimulus(1'b1, 1'b1, 'h900 + k, 'ha00 + k, 'h9000 + 2 * k, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      idle(1'b0);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction fetch queue between instruction fetch and the issue/hazard-detection stage. Buffers fetched instruction pairs, assigns each instruction a monotonically increasing non-zero instruction ID, and presents one pair per cycle as registered outputs to issue. Honours the issue stage's `stall`: the presented pair is held, and nothing is popped. Honours `flush`: all buffered and presented instructions are discarded.

## Interface
- `DEPTH`, 4: queue capacity in instruction pairs; power of two, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `flush`  in  1  discard queue contents and the presented pair.
- `stall`  in  1  stall from issue; hold the outputs and do not pop.
- `fetch_vld`  in  1  fetch presents a pair this cycle.
- `fetch_rdy`  out  1  queue can accept a pair; equals `count < DEPTH`; combinational from state only.
- `fetch_instruction0`, `fetch_instruction1`  in  `INST_WIDTH`  fetched pair; slot 0 is older.
- `fetch_pc`  in  `ADDR_WIDTH`  PC of slot 0; slot 1 PC is `fetch_pc + 1`.
- `instruction0_out`, `instruction1_out`  out  `INST_WIDTH`  pair to issue; 0 is a NOP.
- `pc0_out`, `pc1_out`  out  `ADDR_WIDTH`  PCs of the presented pair.
- `id0_out`, `id1_out`  out  `INSTRUCTION_ID_WIDTH`  instruction IDs; 0 marks a bubble.
- `empty`  out  1  `count == 0`.

## Operation
- **Storage:** circular buffer of `DEPTH` entries. Each entry holds `{inst0, inst1, pc0, id0, id1}`. State is `head`, `tail` (each log2(DEPTH) bits, wrapping modulo DEPTH) and `count` (log2(DEPTH)+1 bits).
- **Push:** `fetch_vld && fetch_rdy`.
  - The entry is written at `tail`, and `tail` increments.
  - IDs are taken from the ID generator at push time: `id0 = next_id`, `id1 = succ(next_id)`, then `next_id = succ(succ(next_id))`.
- **ID generator:** `succ(x) = x + 1`, except that `succ(2^W - 1) = 1`. ID 0 is never issued.
- **Pop:** occurs when `!stall && !flush && count > 0`.
  - The head entry is loaded into the output registers, and `head` increments.
- **Bubble:** when `!stall && count == 0` and no bypass applies, all outputs are loaded with 0.
- **Stall:** all output registers hold their value. Push is still accepted while `fetch_rdy` is high.
- **Same-cycle push and pop:** `count` is unchanged.
  - When full, `fetch_rdy` = 0, so no push occurs in a pop cycle. Room is visible only in the next cycle.
- **Flush:** has priority over push, pop and stall.
  - `head`, `tail` and `count` are set to 0, and all outputs are set to 0.
  - A push presented in the flush cycle is dropped.
  - `next_id` is **not** reset, so IDs stay monotonic across flushes.
- **Reset** (`rst_n` = 0 at the edge):
  - all outputs are 0;
  - `head`, `tail` and `count` are 0;
  - `next_id` = 1;
  - `fetch_rdy` = 1 and `empty` = 1 after the edge.
- **Reset mid-operation:** identical to reset; all content is discarded.

## Timing
- **Queue latency:** a pair pushed at edge N is in the queue after edge N. If it is at the head and `!stall`, it is presented after edge N+1 (2 cycles from the fetch handshake).
- **With bypass** (see Configuration): 1 cycle.
- **Stall:** each stalled cycle adds one cycle of latency.
- **Throughput:** one pair per cycle sustained when `stall` = 0.
- **No combinational paths:** there is no combinational path from `stall`, `flush` or `fetch_vld` to any output.

## Configuration
- **`FETCH_QUEUE_BYPASS_EN` defined:** when `count == 0`, a push and `!stall && !flush` all hold in the same cycle, the pushed pair (with its newly assigned IDs) loads directly into the output registers.
  - The pair is not written to the queue; `tail` and `count` are unchanged.
  - Latency is 1 cycle.
- **Undefined:** every pushed pair goes through the queue; minimum latency is 2 cycles.

## Structure
- **Shared constants:** `INST_WIDTH`, `ADDR_WIDTH` and `INSTRUCTION_ID_WIDTH` come from the shared `defines.vh`.
  - Add `FETCH_QUEUE_DEPTH` there as the top-level value of `DEPTH`.
- **Sub-module `id_gen`:** the skip-zero ID counter.
  - Its output is `next_id`, together with the combinational `id0`/`id1` for the current pair.
  - Input `adv` advances the counter by two.
  - It has its own `clk`/`rst_n` (`next_id` = 1 on reset).
  - It ignores `flush`.

## Test plan
- **Reset then single push:** after reset, push `{inst0=0x11, inst1=0x22, pc=0x40}` with `stall` = 0.
  - Outputs after edge 2 (edge 1 with bypass): instructions 0x11/0x22, PCs 0x40/0x41, IDs 1/2.
  - The next cycle is a bubble: all outputs 0.
- **Fill to full:** hold `stall` = 1 and push 5 pairs with DEPTH = 4.
  - `fetch_rdy` drops after the 4th push; the 5th pair is not accepted.
  - Release `stall`: 4 pairs pop in order over 4 consecutive cycles, with IDs 1..8.
- **Stall hold:** assert `stall` for 3 cycles while a pair with IDs 5/6 is presented.
  - The outputs stay constant through the stall.
  - The pair with IDs 7/8 appears one cycle after `stall` falls.
- **Flush mid-stream:** with 3 pairs queued, assert `flush` together with `fetch_vld`.
  - Next cycle: outputs 0, `empty` = 1, `count` = 0.
  - The next accepted push gets the IDs following the last IDs issued before the flush.
- **ID wrap:** with `INSTRUCTION_ID_WIDTH` = 4, push until `next_id` = 15.
  - The next pair gets IDs 15/1; the following pair gets 2/3. ID 0 never appears on a valid instruction.
- **Reset mid-operation:** deassert `rst_n` for 1 cycle with the queue half-full and `stall` = 1.
  - All outputs are 0, `fetch_rdy` = 1, and the next push receives IDs 1/2.
